vga_scan_gen: RTL and testbench
===============================

VGA_SCAN_GEN -- requirements
Module: vga_scan_gen

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  CLK_DIV 2: clock cycles per pixel.
  H_ACTIVE 640, H_FP 16, H_SYNC 96, H_BP 48: horizontal timing, in pixels.
  V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33: vertical timing, in lines.
  H_TOTAL = sum of the H_* values (800). V_TOTAL = sum of the V_* values (525).
REQ-002 clock  in  1: single clock for all state.
REQ-003 reset  in  1: reset, asynchronous, active-high.
REQ-004 pix_r, pix_g, pix_b  in  10 each: colour from the downstream renderer, a combinational function of x and y.
REQ-005 x  out  10: current horizontal scan count, 0..H_TOTAL-1.
REQ-006 y  out  10: current vertical scan count, 0..V_TOTAL-1.
REQ-007 pix_en  out  1: one-clock pixel strobe.
REQ-008 frame_start  out  1: one-clock pulse.
REQ-009 line_start  out  1: one-clock pulse.
REQ-010 vga_r, vga_g, vga_b  out  10 each: registered DAC colour.
REQ-011 vga_hs, vga_vs  out  1 each: sync outputs, active-low.
REQ-012 vga_blank_n  out  1: low during blanking.
REQ-013 vga_sync_n  out  1: tied to constant 0.

Function
REQ-014 Divider: counts 0..CLK_DIV-1 and wraps; pix_en = 1 exactly when the divider equals CLK_DIV-1; CLK_DIV=1 gives pix_en permanently 1 after reset.
REQ-015 x and y change only in a clock where pix_en=1.
REQ-016 On pix_en: x increments; at x=H_TOTAL-1, x wraps to 0 and y increments; at y=V_TOTAL-1 with that same wrap, y wraps to 0.
REQ-017 active = (x < H_ACTIVE) and (y < V_ACTIVE); both compares unsigned, 10-bit.
REQ-018 hs_raw = 0 iff H_ACTIVE+H_FP <= x <= H_ACTIVE+H_FP+H_SYNC-1, i.e. x in 656..751.
REQ-019 vs_raw = 0 iff V_ACTIVE+V_FP <= y <= V_ACTIVE+V_FP+V_SYNC-1, i.e. y in 490..491.
REQ-020 Output stage, sampled on pix_en:
  vga_r/g/b = pix_r/g/b if active, else 0.
  vga_blank_n = active.
  vga_hs = hs_raw; vga_vs = vs_raw.
  All of these registers hold their value while pix_en=0.
REQ-021 Latency: vga_* outputs lag the x/y that produced them by exactly one pixel period (CLK_DIV clocks). Sync, blank and colour stay mutually aligned.
REQ-022 line_start = 1 for one clock when pix_en=1 and x=H_TOTAL-1 (the line wrap clock).
REQ-023 frame_start = 1 for one clock when pix_en=1, x=H_TOTAL-1 and y=V_TOTAL-1. In that clock line_start is also 1.
REQ-024 Colour inputs are ignored outside the active area, whatever their value.
REQ-025 Parameter sums must fit 10 bits (H_TOTAL <= 1023, V_TOTAL <= 1023); larger values are unsupported.

Reset
REQ-026 While reset=1, immediately and independent of clock:
  divider=0, x=0, y=0.
  pix_en=0, frame_start=0, line_start=0.
  vga_r/g/b=0, vga_blank_n=0, vga_hs=1, vga_vs=1.
REQ-027 After reset deasserts, the first pix_en occurs on clock edge CLK_DIV; x becomes 1 on that edge.
REQ-028 Reset asserted mid-line or mid-frame aborts the scan; the next frame starts from (0,0) with no partial-sync pulse carried over.

Verification
REQ-029 Reset release, CLK_DIV=2 -> pix_en high on every 2nd clock; x sequence 0,1,2,... advancing each pix_en; y=0.
REQ-030 Full line -> vga_hs low for exactly 96 pixel periods, beginning one pixel after x=656; line_start pulses once per 800 pixels.
REQ-031 Full frame -> vga_vs low for exactly 2 lines (1600 pixels), aligned to y=490 with one pixel lag; frame_start pulses once per 800*525=420000 pixel periods.
REQ-032 Blank gating: pix_r=pix_g=pix_b=10'h3FF held constant -> vga_r=3FF only for the 640x480 active region; 0 at x=640..799 and y=480..524; vga_blank_n matches.
REQ-033 Alignment: pix_r = x[9:0] -> vga_r equals the previous pixel's x (e.g. vga_r=5 while x=6), rows 0..479.
REQ-034 Reset pulse at x=700, y=491 (hs and vs both low) -> vga_hs=vga_vs=1, x=y=0 immediately; the next vsync occurs a full 490 lines later.

Source files
------------

// File: rtl/vga_scan_gen.sv
// vga_scan_gen: VGA raster timing generator with a registered colour/sync
// output stage.
//
// A clock divider produces a pixel strobe (pix_en) every CLK_DIV clocks. On
// each strobe the (x, y) scan counters advance across the full raster,
// including blanking. The current (x, y) is decoded into active/hsync/vsync,
// and the colour from the downstream renderer is gated and captured so that
// all vga_* outputs lag the producing x/y by exactly one pixel period.
//
// Ports:
//   clock                 single clock for all state
//   reset                 asynchronous, active-high
//   pix_r/pix_g/pix_b     renderer colour, a combinational function of x, y
//   x, y                  current scan position (0..H_TOTAL-1, 0..V_TOTAL-1)
//   pix_en                one-clock pixel strobe
//   line_start            one-clock pulse on the line wrap strobe
//   frame_start           one-clock pulse on the frame wrap strobe
//   vga_r/vga_g/vga_b     registered DAC colour, zero outside active area
//   vga_hs, vga_vs        sync outputs, active-low
//   vga_blank_n           low during blanking
//   vga_sync_n            constant 0
module vga_scan_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [9:0] pix_r,
  input  logic [9:0] pix_g,
  input  logic [9:0] pix_b,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       pix_en,
  output logic       frame_start,
  output logic       line_start,
  output logic [9:0] vga_r,
  output logic [9:0] vga_g,
  output logic [9:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       vga_sync_n
);

  localparam int DATA_W  = 10;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Inclusive unsigned window test used for both sync decodes.
  function automatic logic in_window(input logic [9:0] v,
                                     input logic [9:0] lo,
                                     input logic [9:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  logic [DIV_W-1:0] div;
  logic             vld_p0;
  logic             active_p0;
  logic             hs_raw_p0;
  logic             vs_raw_p0;
  logic             x_wrap;
  logic             y_wrap;

  logic [DATA_W-1:0] r_p1;
  logic [DATA_W-1:0] g_p1;
  logic [DATA_W-1:0] b_p1;
  logic              blank_n_p1;
  logic              hs_p1;
  logic              vs_p1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div <= '0;
    end else if (div == DIV_LAST) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  // The strobe is decoded straight from the divider so that the first strobe
  // lands on clock edge CLK_DIV after release (and is continuous when
  // CLK_DIV=1); reset gates it so it reads 0 immediately while held.
  assign pix_en = ~reset & (div == DIV_LAST);
  assign vld_p0 = pix_en;

  assign x_wrap      = (x == H_LAST);
  assign y_wrap      = (y == V_LAST);
  assign line_start  = vld_p0 & x_wrap;
  assign frame_start = vld_p0 & x_wrap & y_wrap;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else if (vld_p0) begin
      if (x_wrap) begin
        x <= '0;
        y <= y_wrap ? 10'd0 : y + 10'd1;
      end else begin
        x <= x + 10'd1;
      end
    end
  end

  // ---- stage p0: decode of the current scan position ----
  assign active_p0 = (x < H_ACT) && (y < V_ACT);
  assign hs_raw_p0 = ~in_window(x, HS_FIRST, HS_LAST);
  assign vs_raw_p0 = ~in_window(y, VS_FIRST, VS_LAST);

  // ---- stage p1: registered DAC outputs, one pixel behind x/y ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_p1       <= '0;
      g_p1       <= '0;
      b_p1       <= '0;
      blank_n_p1 <= 1'b0;
      hs_p1      <= 1'b1;
      vs_p1      <= 1'b1;
    end else if (vld_p0) begin
      r_p1       <= active_p0 ? pix_r : '0;
      g_p1       <= active_p0 ? pix_g : '0;
      b_p1       <= active_p0 ? pix_b : '0;
      blank_n_p1 <= active_p0;
      hs_p1      <= hs_raw_p0;
      vs_p1      <= vs_raw_p0;
    end
  end

  assign vga_r       = r_p1;
  assign vga_g       = g_p1;
  assign vga_b       = b_p1;
  assign vga_blank_n = blank_n_p1;
  assign vga_hs      = hs_p1;
  assign vga_vs      = vs_p1;
  assign vga_sync_n  = 1'b0;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Testbench for vga_scan_gen using a reduced raster so whole frames fit in a
// short run. The reference model derives the scan position from the number
// of clocks since reset release; expected DAC outputs are queued on every
// predicted pixel strobe and checked by an independent monitor.
module tb_vga_scan_gen;

  localparam int D  = 2;
  localparam int HA = 16, HF = 4, HS = 6, HB = 6;
  localparam int VA = 10, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;   // 32
  localparam int VT = VA + VF + VS + VB;   // 17
  localparam int FRAME_CLKS = HT * VT * D;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] pr, pg, pb;
  logic [9:0] x, y, vr, vg, vb;
  logic       pix_en, frame_start, line_start, hs, vs, blank_n, sync_n;

  logic [9:0] x1, y1, vr1, vg1, vb1;
  logic       pix_en1, fs1, ls1, hs1, vs1, blank_n1, sync_n1;

  int tests = 0;
  int fails = 0;
  int mode  = 0;
  int k     = 0;

  logic [9:0] tab_r [0:1023];
  logic [9:0] tab_g [0:1023];
  logic [9:0] tab_b [0:1023];

  typedef struct packed {
    logic [9:0] r, g, b;
    logic       blank_n, hs, vs;
  } vga_t;
  vga_t q[$];

  always #5 clk = ~clk;

  // Renderer: colour as a function of the DUT's scan position.
  logic [9:0] taddr;
  assign taddr = 10'(int'(y) * HT + int'(x));
  assign pr = (mode == 1) ? 10'h3FF : (mode == 2) ? x : tab_r[taddr];
  assign pg = (mode == 1) ? 10'h3FF : (mode == 2) ? y : tab_g[taddr];
  assign pb = (mode == 1) ? 10'h3FF : (mode == 2) ? (x ^ y) : tab_b[taddr];

  vga_scan_gen #(
    .CLK_DIV(D), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clock(clk), .reset(rst), .pix_r(pr), .pix_g(pg), .pix_b(pb),
    .x(x), .y(y), .pix_en(pix_en), .frame_start(frame_start),
    .line_start(line_start), .vga_r(vr), .vga_g(vg), .vga_b(vb),
    .vga_hs(hs), .vga_vs(vs), .vga_blank_n(blank_n), .vga_sync_n(sync_n)
  );

  vga_scan_gen #(
    .CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut_div1 (
    .clock(clk), .reset(rst), .pix_r(10'h0), .pix_g(10'h0), .pix_b(10'h0),
    .x(x1), .y(y1), .pix_en(pix_en1), .frame_start(fs1),
    .line_start(ls1), .vga_r(vr1), .vga_g(vg1), .vga_b(vb1),
    .vga_hs(hs1), .vga_vs(vs1), .vga_blank_n(blank_n1), .vga_sync_n(sync_n1)
  );

  task automatic check_eq(input string name, input logic [31:0] act,
                          input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] col(input int ch, input int px, input int py);
    logic [9:0] a;
    a = 10'(py * HT + px);
    case (mode)
      1: return 10'h3FF;
      2: return (ch == 0) ? 10'(px) : (ch == 1) ? 10'(py) : 10'(px ^ py);
      default: return (ch == 0) ? tab_r[a] : (ch == 1) ? tab_g[a] : tab_b[a];
    endcase
  endfunction

  // Expected DAC state produced by pixel (px, py).
  function automatic vga_t ref_out(input int px, input int py);
    vga_t e;
    bit act;
    act       = (px < HA) && (py < VA);
    e.r       = act ? col(0, px, py) : 10'h0;
    e.g       = act ? col(1, px, py) : 10'h0;
    e.b       = act ? col(2, px, py) : 10'h0;
    e.blank_n = act;
    e.hs      = !((px >= HA + HF) && (px < HA + HF + HS));
    e.vs      = !((py >= VA + VF) && (py < VA + VF + VS));
    return e;
  endfunction

  // State after kk clock edges since reset release.
  task automatic check_state(input int kk);
    int p, px, py;
    bit pe;
    p  = kk / D;
    px = p % HT;
    py = (p / HT) % VT;
    pe = (kk % D) == D - 1;
    check_eq("x", 32'(x), 32'(px));
    check_eq("y", 32'(y), 32'(py));
    check_eq("pix_en", 32'(pix_en), 32'(pe));
    check_eq("line_start", 32'(line_start), 32'(pe && px == HT - 1));
    check_eq("frame_start", 32'(frame_start),
             32'(pe && px == HT - 1 && py == VT - 1));
    check_eq("div1_pix_en", 32'(pix_en1), 32'd1);
    check_eq("div1_x", 32'(x1), 32'(kk % HT));
    check_eq("div1_y", 32'(y1), 32'((kk / HT) % VT));
    if (pe) q.push_back(ref_out(px, py));
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      k++;
      check_state(k);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_x"}, 32'(x), 32'd0);
    check_eq({tag, "_y"}, 32'(y), 32'd0);
    check_eq({tag, "_pix_en"}, 32'(pix_en), 32'd0);
    check_eq({tag, "_line_start"}, 32'(line_start), 32'd0);
    check_eq({tag, "_frame_start"}, 32'(frame_start), 32'd0);
    check_eq({tag, "_vga_rgb"}, 32'({vr, vg, vb}), 32'd0);
    check_eq({tag, "_blank_n"}, 32'(blank_n), 32'd0);
    check_eq({tag, "_hs"}, 32'(hs), 32'd1);
    check_eq({tag, "_vs"}, 32'(vs), 32'd1);
    check_eq({tag, "_div1_pix_en"}, 32'(pix_en1), 32'd0);
    check_eq({tag, "_div1_x"}, 32'(x1), 32'd0);
  endtask

  // Assert reset away from a clock edge, check it acts at once, then release.
  task automatic reset_pulse(input int new_mode);
    #2 rst = 1'b1;
    q.delete();
    #1 check_reset_vals("rst_async");
    mode = new_mode;
    @(negedge clk);
    check_reset_vals("rst_held");
    rst = 1'b0;
    k   = 0;
    #1 check_state(0);
  endtask

  // Monitor: after every clock edge on which the DUT strobed, the registered
  // outputs must match the oldest queued expectation.
  bit pe_seen = 1'b0;
  always @(posedge clk) pe_seen <= pix_en;

  always @(negedge clk) begin
    if (pe_seen) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL vga_queue: DUT strobed with no expected pixel queued (t=%0t)", $time);
      end else begin
        vga_t e;
        e = q.pop_front();
        check_eq("vga_r", 32'(vr), 32'(e.r));
        check_eq("vga_g", 32'(vg), 32'(e.g));
        check_eq("vga_b", 32'(vb), 32'(e.b));
        check_eq("vga_blank_n", 32'(blank_n), 32'(e.blank_n));
        check_eq("vga_hs", 32'(hs), 32'(e.hs));
        check_eq("vga_vs", 32'(vs), 32'(e.vs));
        check_eq("vga_sync_n", 32'(sync_n), 32'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam int MID_CLKS = (12 * HT + 22) * D;  // position x=22, y=12

  initial begin
    for (int i = 0; i < 1024; i++) begin
      tab_r[i] = 10'($urandom);
      tab_g[i] = 10'($urandom);
      tab_b[i] = 10'($urandom);
    end
    mode = 0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst_init");
    rst = 1'b0;
    k   = 0;
    #1 check_state(0);

    // Random colours over two whole frames, then stop inside both sync pulses.
    run(2 * FRAME_CLKS + MID_CLKS);
    check_eq("pre_reset_hs_low", 32'(hs), 32'd0);
    check_eq("pre_reset_vs_low", 32'(vs), 32'd0);
    reset_pulse(1);

    // Constant full-scale colour: blank gating over a frame, then reset again
    // inside the sync region.
    run(FRAME_CLKS + MID_CLKS);
    reset_pulse(2);

    // Colour follows position: checks the one-pixel alignment.
    run(FRAME_CLKS + 50);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
